csc_stream_sram: RTL

Parametrised successor of the iact address SRAM: buffers zero-terminated CSC streams (one zero ends a stream, two consecutive zeros seal the buffer) and records each stream's start address in an internal look-up table. It adds generic width, depth and stream count, overflow protection, stream-index bounds checking, an explicit clear, and a fully backpressured valid/ready read port with a last-beat flag. It sits in the GLB cluster between the CSC encoder and the PE-side iact readers, and is usable for address or data SRAMs.

---
 rtl/csc_stream_sram_if.sv | 41 ++++
 rtl/csc_stream_sram.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/csc_stream_sram_if.sv
`default_nettype none
// ============================================================================
// Module  : csc_stream_sram_if
// Brief   : Write-side and read-side handshake bundle of csc_stream_sram.
// Rev     : 1.0  initial release
// ============================================================================
interface csc_stream_sram_if #(
   parameter int DATA_WIDTH  = 7,
   parameter int MAX_STREAMS = 32
);
   localparam int SID_W = $clog2(MAX_STREAMS);

   logic                  write_en;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  write_done;
   logic [SID_W:0]        stream_count;
   logic                  overflow;
   logic                  read_start;
   logic [SID_W-1:0]      read_stream;
   logic                  read_err;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  read_done;

   modport master (
      output write_en, in_valid, in_data, read_start, read_stream, out_ready,
      input  in_ready, write_done, stream_count, overflow, read_err,
             out_valid, out_data, out_last, read_done
   );

   modport slave (
      input  write_en, in_valid, in_data, read_start, read_stream, out_ready,
      output in_ready, write_done, stream_count, overflow, read_err,
             out_valid, out_data, out_last, read_done
   );
endinterface
`default_nettype wire

// File: rtl/csc_stream_sram.sv
`default_nettype none
// ============================================================================
// Module  : csc_stream_sram
// Brief   : Zero-terminated CSC stream buffer with start-address LUT and a
//           backpressured read port.
// Rev     : 1.0  initial release
// ============================================================================
module csc_stream_sram #(
   parameter int DATA_WIDTH  = 7,
   parameter int SRAM_DEPTH  = 512,
   parameter int MAX_STREAMS = 32
) (
   input wire clock,
   input wire reset_n,
   input wire clear,
   csc_stream_sram_if.slave bus
);
   localparam int ADDR_W = $clog2(SRAM_DEPTH);
   localparam int SID_W  = $clog2(MAX_STREAMS);
   localparam logic [ADDR_W:0] c_depth      = (ADDR_W+1)'(SRAM_DEPTH);
   localparam logic [SID_W:0]  c_maxStreams = (SID_W+1)'(MAX_STREAMS);

   typedef enum logic [1:0] {W_DATA = 2'd0, W_ZERO1 = 2'd1, W_DONE = 2'd2} wState_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_RUN = 1'b1} rState_t;

   logic [DATA_WIDTH-1:0] r_mem [SRAM_DEPTH];
   logic [ADDR_W-1:0]     r_lut [MAX_STREAMS];

   wState_t               r_wState;
   logic [ADDR_W:0]       r_wrPtr;
   logic [SID_W:0]        r_streamCount;
   logic                  r_overflow;
   logic                  r_writeDone;

   rState_t               r_rState;
   logic [ADDR_W-1:0]     r_rdPtr;
   logic                  r_termFetched;
   logic [DATA_WIDTH-1:0] r_memQ;
   logic                  r_memQValid;
   logic [DATA_WIDTH-1:0] r_head;
   logic                  r_headValid;
   logic                  r_headLast;
   logic [DATA_WIDTH-1:0] r_skid;
   logic                  r_skidValid;
   logic                  r_readErr;
   logic                  r_readDone;

   wire w_clr        = !reset_n || clear;
   wire w_inZero     = (bus.in_data == '0);
   wire w_spaceOk    = (r_wrPtr < c_depth);
   wire w_streamFull = (r_wState == W_ZERO1) && (r_streamCount == c_maxStreams) && !w_inZero;
   wire w_inReady    = bus.write_en && !r_overflow && (r_wState != W_DONE) && w_spaceOk && !w_streamFull;
   wire w_wrFire     = bus.in_valid && w_inReady;
   wire w_dropZero   = w_wrFire && (r_wState == W_DATA) && w_inZero && (r_wrPtr == '0);
   wire w_wrStore    = w_wrFire && !w_dropZero;
   wire w_streamEnd  = w_wrFire && (r_wState == W_DATA) && w_inZero && (r_wrPtr != '0);
   wire w_refuse     = bus.write_en && bus.in_valid && !w_inReady && (r_wState != W_DONE)
                       && (!w_spaceOk || w_streamFull);
   wire [SID_W:0] w_nextCount = r_streamCount + 1'b1;
   wire w_lutWrite   = w_streamEnd && (w_nextCount < c_maxStreams);

   wire w_startReq = (r_rState == R_IDLE) && bus.read_start;
   wire w_startOk  = w_startReq && (r_wState == W_DONE) && ({1'b0, bus.read_stream} < r_streamCount);
   wire w_startErr = w_startReq && !w_startOk;
   wire w_pop      = r_headValid && bus.out_ready;

   // The fetch may only issue if its word is guaranteed a slot in the
   // two-entry output queue once it lands, counting this cycle's pop.
   wire [1:0] w_occ  = 2'(r_headValid) + 2'(r_skidValid) + 2'(r_memQValid);
   wire       w_room = (w_occ <= (2'd1 + 2'(w_pop)));
   wire       w_fetch = w_startOk || ((r_rState == R_RUN) && !r_termFetched && w_room);
   wire [ADDR_W-1:0]     w_fetchAddr = (r_rState == R_IDLE) ? r_lut[bus.read_stream] : r_rdPtr;
   wire [DATA_WIDTH-1:0] w_fetchWord = r_mem[w_fetchAddr];

   always_ff @(posedge clock) begin
      if (w_wrStore) r_mem[r_wrPtr[ADDR_W-1:0]] <= bus.in_data;
   end

   // Entry 0 is the only LUT slot with a defined value before any stream ends.
   always_ff @(posedge clock) begin
      if (w_clr)           r_lut[0] <= '0;
      else if (w_lutWrite) r_lut[w_nextCount[SID_W-1:0]] <= r_wrPtr[ADDR_W-1:0] + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (w_clr) begin
         r_wState      <= W_DATA;
         r_wrPtr       <= '0;
         r_streamCount <= '0;
         r_overflow    <= 1'b0;
         r_writeDone   <= 1'b0;
      end else begin
         r_writeDone <= w_wrFire && (r_wState == W_ZERO1) && w_inZero;
         if (w_refuse)  r_overflow <= 1'b1;
         if (w_wrStore) r_wrPtr <= r_wrPtr + 1'b1;
         case (r_wState)
            W_DATA: if (w_streamEnd) begin
               r_streamCount <= w_nextCount;
               r_wState      <= W_ZERO1;
            end
            W_ZERO1: if (w_wrFire) r_wState <= w_inZero ? W_DONE : W_DATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_clr) begin
         r_rState      <= R_IDLE;
         r_rdPtr       <= '0;
         r_termFetched <= 1'b0;
         r_memQ        <= '0;
         r_memQValid   <= 1'b0;
         r_head        <= '0;
         r_headValid   <= 1'b0;
         r_headLast    <= 1'b0;
         r_skid        <= '0;
         r_skidValid   <= 1'b0;
         r_readErr     <= 1'b0;
         r_readDone    <= 1'b0;
      end else begin
         r_readErr   <= w_startErr;
         r_readDone  <= w_pop && r_headLast;
         r_memQValid <= w_fetch;
         if (w_fetch) begin
            r_memQ        <= w_fetchWord;
            r_rdPtr       <= w_fetchAddr + 1'b1;
            r_termFetched <= (w_fetchWord == '0);
         end
         if (r_rState == R_IDLE) begin
            if (w_startOk) r_rState <= R_RUN;
         end else begin
            if (!r_headValid || w_pop) begin
               if (r_skidValid) begin
                  r_head      <= r_skid;
                  r_headLast  <= (r_skid == '0);
                  r_headValid <= 1'b1;
                  r_skid      <= r_memQ;
                  r_skidValid <= r_memQValid;
               end else begin
                  r_head      <= r_memQValid ? r_memQ : r_head;
                  r_headLast  <= r_memQValid && (r_memQ == '0);
                  r_headValid <= r_memQValid;
               end
            end else if (r_memQValid) begin
               r_skid      <= r_memQ;
               r_skidValid <= 1'b1;
            end
            if (w_pop && r_headLast) r_rState <= R_IDLE;
         end
      end
   end

   assign bus.in_ready     = w_inReady;
   assign bus.write_done   = r_writeDone;
   assign bus.stream_count = r_streamCount;
   assign bus.overflow     = r_overflow;
   assign bus.read_err     = r_readErr;
   assign bus.out_valid    = r_headValid;
   assign bus.out_data     = r_head;
   assign bus.out_last     = r_headLast;
   assign bus.read_done    = r_readDone;
endmodule
`default_nettype wire
